// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared snake game types
package snake_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } direction;

endpackage

// File: rtl/snake_link.sv
// rtl/snake_link.sv - byte-frame link engine between the snake core and the UART
module snake_link
    import snake_pkg::*;
#(
    parameter int FIFO_DEPTH       = 4,
    parameter int KEEPALIVE_CYCLES = 250000,
    parameter int TIMEOUT_CYCLES   = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_dir,
    input  direction   dir_in,
    input  logic       send_col,
    input  logic [5:0] col_in,
    input  logic       send_click,
    input  logic [5:0] click_in,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output direction   dir_out,
    output logic       rcvdir,
    output logic [5:0] col_out,
    output logic       rcvcol,
    output logic [5:0] click_out,
    output logic       rcvclick,
    output logic [7:0] err_cnt,
    output logic       link_up,
    output logic       tx_busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int KW = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DW = $bits(direction);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [KW-1:0] KA_LAST  = KW'(KEEPALIVE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          send_dir_q, send_col_q, send_click_q;
    logic          pend_dir, pend_col, pend_click;
    logic [5:0]    dir_pay, col_pay, click_pay;
    logic [KW-1:0] idle_cnt;
    logic [TW-1:0] to_cnt;

    logic          rise_dir, rise_col, rise_click;
    logic          fifo_full, fifo_empty;
    logic          take_dir, take_col, take_click, push, pop, ka_fire, rd_fire;
    logic [7:0]    push_byte;
    logic          dec_dir, dec_col, dec_click, dec_err;

    assign rise_dir   = send_dir & ~send_dir_q;
    assign rise_col   = send_col & ~send_col_q;
    assign rise_click = send_click & ~send_click_q;
    assign tx_busy    = (count != '0) | pend_dir | pend_col | pend_click;

    // One pending request per cycle enters the queue: collision, then direction, then click.
    always_comb begin
        fifo_full  = (count == FULL_CNT);
        fifo_empty = (count == '0);
        take_col   = 1'b0;
        take_dir   = 1'b0;
        take_click = 1'b0;
        push_byte  = 8'h00;
        if (!fifo_full) begin
            if (pend_col) begin
                take_col  = 1'b1;
                push_byte = {2'b10, col_pay};
            end else if (pend_dir) begin
                take_dir  = 1'b1;
                push_byte = {2'b01, dir_pay};
            end else if (pend_click) begin
                take_click = 1'b1;
                push_byte  = {2'b11, click_pay};
            end
        end
        push    = take_col | take_dir | take_click;
        pop     = !fifo_empty && !tx_full && !wr_uart;
        ka_fire = fifo_empty && !pend_dir && !pend_col && !pend_click &&
                  !tx_full && !wr_uart && (idle_cnt == KA_LAST);
        rd_fire = !rx_empty && !rd_uart;
    end

    always_comb begin
        dec_dir   = 1'b0;
        dec_col   = 1'b0;
        dec_click = 1'b0;
        dec_err   = 1'b0;
        case (r_data[7:6])
            2'b00: dec_err = (r_data[5:0] != 6'd0);
            2'b01: begin
                if (r_data[5:DW] == '0) dec_dir = 1'b1;
                else                    dec_err = 1'b1;
            end
            2'b10:   dec_col   = 1'b1;
            default: dec_click = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_dir_q   <= 1'b0;
            send_col_q   <= 1'b0;
            send_click_q <= 1'b0;
            pend_dir     <= 1'b0;
            pend_col     <= 1'b0;
            pend_click   <= 1'b0;
            dir_pay      <= 6'd0;
            col_pay      <= 6'd0;
            click_pay    <= 6'd0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            idle_cnt     <= '0;
            to_cnt       <= '0;
            wr_uart      <= 1'b0;
            w_data       <= 8'h00;
            rd_uart      <= 1'b0;
            dir_out      <= NONE;
            rcvdir       <= 1'b0;
            col_out      <= 6'd0;
            rcvcol       <= 1'b0;
            click_out    <= 6'd0;
            rcvclick     <= 1'b0;
            err_cnt      <= 8'd0;
            link_up      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            send_dir_q   <= send_dir;
            send_col_q   <= send_col;
            send_click_q <= send_click;
            // A fresh edge in the cycle its own request is queued re-arms the pending flag.
            pend_dir   <= rise_dir   | (pend_dir   & ~take_dir);
            pend_col   <= rise_col   | (pend_col   & ~take_col);
            pend_click <= rise_click | (pend_click & ~take_click);
            if (rise_dir)   dir_pay   <= 6'(dir_in);
            if (rise_col)   col_pay   <= col_in;
            if (rise_click) click_pay <= click_in;

            if (push) begin
                mem[wr_ptr] <= push_byte;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);

            wr_uart <= pop | ka_fire;
            if (pop)          w_data <= mem[rd_ptr];
            else if (ka_fire) w_data <= 8'h00;

            if (wr_uart)                  idle_cnt <= '0;
            else if (idle_cnt != KA_LAST) idle_cnt <= idle_cnt + 1'b1;

            rd_uart  <= rd_fire;
            rcvdir   <= rd_fire & dec_dir;
            rcvcol   <= rd_fire & dec_col;
            rcvclick <= rd_fire & dec_click;
            if (rd_fire && dec_dir)   dir_out   <= direction'(r_data[DW-1:0]);
            if (rd_fire && dec_col)   col_out   <= r_data[5:0];
            if (rd_fire && dec_click) click_out <= r_data[5:0];
            if (rd_fire && dec_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

            if (rd_fire) begin
                to_cnt  <= '0;
                link_up <= 1'b1;
            end else if (to_cnt == TO_LAST) begin
                link_up <= 1'b0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snake_link.sv
// tb/tb_snake_link.sv - randomized self-checking bench for snake_link
module tb_snake_link;
    import snake_pkg::*;

    localparam int DEPTH = 4;
    localparam int KA    = 10;
    localparam int TO    = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send_dir, send_col, send_click;
    direction   dir_in;
    logic [5:0] col_in, click_in;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    direction   dir_out;
    logic       rcvdir, rcvcol, rcvclick;
    logic [5:0] col_out, click_out;
    logic [7:0] err_cnt;
    logic       link_up, tx_busy;

    snake_link #(
        .FIFO_DEPTH      (DEPTH),
        .KEEPALIVE_CYCLES(KA),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_dir  (send_dir),
        .dir_in    (dir_in),
        .send_col  (send_col),
        .col_in    (col_in),
        .send_click(send_click),
        .click_in  (click_in),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .dir_out   (dir_out),
        .rcvdir    (rcvdir),
        .col_out   (col_out),
        .rcvcol    (rcvcol),
        .click_out (click_out),
        .rcvclick  (rcvclick),
        .err_cnt   (err_cnt),
        .link_up   (link_up),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [7:0] tx_q[$];
    int         tx_t[$];
    logic [7:0] data_q[$];

    logic [2:0] exp_dir;
    logic [5:0] exp_col, exp_click;
    int         exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && wr_uart) begin
            tx_q.push_back(w_data);
            tx_t.push_back(cyc);
            if (w_data != 8'h00) data_q.push_back(w_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        exp_dir   = 3'(NONE);
        exp_col   = 6'd0;
        exp_click = 6'd0;
        exp_err   = 0;
    endfunction

    // Frame rules: op 0 is keepalive only with payload 0; op 1 needs payload < 8.
    function automatic logic [2:0] rx_model(input logic [7:0] b);
        int op, pay;
        logic [2:0] s;
        op  = int'(b) / 64;
        pay = int'(b) % 64;
        s   = 3'b000;
        if (op == 0) begin
            if (pay != 0) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end else if (op == 1) begin
            if (pay < 8) begin
                exp_dir = 3'(pay);
                s = 3'b100;
            end else begin
                exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            end
        end else if (op == 2) begin
            exp_col = 6'(pay);
            s = 3'b010;
        end else begin
            exp_click = 6'(pay);
            s = 3'b001;
        end
        return s;
    endfunction

    task automatic rx_byte(input logic [7:0] b, output bit got);
        r_data   = b;
        rx_empty = 1'b0;
        got      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rd_uart) begin
                got = 1'b1;
                break;
            end
        end
        rx_empty = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!tx_busy && !wr_uart) break;
        end
        @(negedge clk);
    endtask

    task automatic clear_log();
        tx_q.delete();
        tx_t.delete();
        data_q.delete();
    endtask

    task automatic wait_data(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (data_q.size() >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; send_dir = 1'b0; send_col = 1'b0; send_click = 1'b0;
        dir_in = NONE; col_in = 6'd0; click_in = 6'd0;
        rx_empty = 1'b1; r_data = 8'h00; tx_full = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({wr_uart, rd_uart, rcvdir, rcvcol, rcvclick, link_up, tx_busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 0000000",
                     {wr_uart, rd_uart, rcvdir, rcvcol, rcvclick, link_up, tx_busy});
        end
        n_cmp++;
        if (w_data !== 8'h00 || err_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: w_data=%h err_cnt=%h want 00 00", w_data, err_cnt);
        end
        n_cmp++;
        if (dir_out !== NONE || col_out !== 6'd0 || click_out !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_rx_out: dir=%0d col=%h click=%h want 0 0 0",
                     dir_out, col_out, click_out);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_rx_dir();
        logic [7:0] b;
        b = 8'h40 | 8'(LEFT);
        @(negedge clk);
        r_data   = b;
        rx_empty = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rd_uart, rcvdir, link_up} !== 3'b111 || dir_out !== LEFT) begin
            n_fail++;
            $display("FAIL rx_dir_first: rd=%b rcvdir=%b link=%b dir=%0d want 1 1 1 %0d",
                     rd_uart, rcvdir, link_up, dir_out, LEFT);
        end
        @(negedge clk);
        n_cmp++;
        if ({rd_uart, rcvdir} !== 2'b00 || dir_out !== LEFT) begin
            n_fail++;
            $display("FAIL rx_dir_spacing: rd=%b rcvdir=%b dir=%0d want 0 0 %0d",
                     rd_uart, rcvdir, dir_out, LEFT);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_uart !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_dir_second: rd=%b want 1", rd_uart);
        end
        rx_empty = 1'b1;
        void'(rx_model(b));
    endtask

    task automatic test_err_sat();
        logic [7:0] seq[$];
        logic [2:0] s;
        bit got;
        seq = {8'h01, 8'h3F};
        for (int i = 0; i < 300; i++) begin
            seq.push_back(8'h00);
            seq.push_back(8'h01);
        end
        foreach (seq[i]) begin
            rx_byte(seq[i], got);
            s = rx_model(seq[i]);
            n_cmp++;
            if (!got || {rcvdir, rcvcol, rcvclick} !== s || err_cnt !== 8'(exp_err)) begin
                n_fail++;
                $display("FAIL err_sat[%0d]: got=%b strobes=%b err=%0d want 1 %b %0d",
                         i, got, {rcvdir, rcvcol, rcvclick}, err_cnt, s, exp_err);
            end
            if (i < 2) begin
                n_cmp++;
                if (err_cnt !== 8'(i + 1)) begin
                    n_fail++;
                    $display("FAIL err_first[%0d]: err=%0d want %0d", i, err_cnt, i + 1);
                end
            end
        end
        n_cmp++;
        if (err_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL err_saturate: err=%0d want 255", err_cnt);
        end
    endtask

    task automatic test_tx_priority();
        logic [7:0] exp[$];
        drain();
        clear_log();
        col_in = 6'h05; click_in = 6'h2A; dir_in = UP;
        send_col = 1'b1; send_dir = 1'b1; send_click = 1'b1;
        @(negedge clk);
        send_col = 1'b0; send_dir = 1'b0; send_click = 1'b0;
        exp = {8'h85, 8'h40 | 8'(UP), 8'hEA};
        wait_data(3, 40);
        n_cmp++;
        if (data_q.size() != 3) begin
            n_fail++;
            $display("FAIL prio_count: got %0d bytes want 3", data_q.size());
        end
        for (int i = 0; i < 3 && i < data_q.size(); i++) begin
            n_cmp++;
            if (data_q[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL prio_byte[%0d]: got %h want %h", i, data_q[i], exp[i]);
            end
        end
        for (int i = 1; i < tx_t.size(); i++) begin
            n_cmp++;
            if (tx_t[i] - tx_t[i-1] < 2) begin
                n_fail++;
                $display("FAIL prio_spacing[%0d]: gap %0d want >=2", i, tx_t[i] - tx_t[i-1]);
            end
        end
    endtask

    // Queue holds DEPTH bytes plus one pending click; later edges overwrite that pending one.
    task automatic test_tx_full(input int nedges);
        logic [7:0] exp[$];
        logic [5:0] p;
        drain();
        tx_full = 1'b1;
        @(negedge clk);
        clear_log();
        for (int k = 0; k < nedges; k++) begin
            p = 6'($urandom_range(0, 63));
            click_in   = p;
            send_click = 1'b1;
            @(negedge clk);
            send_click = 1'b0;
            if (exp.size() < DEPTH + 1) exp.push_back({2'b11, p});
            else                        exp[exp.size() - 1] = {2'b11, p};
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (tx_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_busy[%0d]: tx_busy=%b want 1", k, tx_busy);
                end
                if (j == 0) @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (tx_q.size() != 0 || tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_blocked: writes=%0d busy=%b want 0 1", tx_q.size(), tx_busy);
        end
        tx_full = 1'b0;
        wait_data(exp.size(), 60);
        n_cmp++;
        if (data_q.size() != exp.size()) begin
            n_fail++;
            $display("FAIL full_count: got %0d want %0d", data_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < data_q.size(); i++) begin
            n_cmp++;
            if (data_q[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL full_byte[%0d]: got %h want %h", i, data_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_keepalive_link();
        bit got;
        int rd_cyc, fall;
        drain();
        rx_byte(8'h00, got);
        rd_cyc = cyc;
        void'(rx_model(8'h00));
        n_cmp++;
        if (!got || link_up !== 1'b1) begin
            n_fail++;
            $display("FAIL link_rise: got=%b link=%b want 1 1", got, link_up);
        end
        clear_log();
        fall = -1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (fall < 0 && !link_up) fall = cyc;
        end
        n_cmp++;
        if (fall - rd_cyc != TO) begin
            n_fail++;
            $display("FAIL link_fall: fell after %0d cycles want %0d", fall - rd_cyc, TO);
        end
        n_cmp++;
        if (tx_q.size() < 4) begin
            n_fail++;
            $display("FAIL ka_count: got %0d keepalives want >=4", tx_q.size());
        end
        for (int i = 0; i < tx_q.size(); i++) begin
            n_cmp++;
            if (tx_q[i] !== 8'h00 || (i > 0 && tx_t[i] - tx_t[i-1] != KA + 1)) begin
                n_fail++;
                $display("FAIL ka_period[%0d]: byte=%h gap=%0d want 00 %0d",
                         i, tx_q[i], (i > 0) ? tx_t[i] - tx_t[i-1] : KA + 1, KA + 1);
            end
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        drain();
        tx_full = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            click_in   = 6'($urandom_range(0, 63));
            send_click = 1'b1;
            @(negedge clk);
            send_click = 1'b0;
            @(negedge clk);
        end
        tx_full = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr_uart) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL arst_setup: no write seen want wr_uart=1");
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({wr_uart, rd_uart, link_up, tx_busy, rcvdir, rcvcol, rcvclick} !== 7'b0 ||
            w_data !== 8'h00 || err_cnt !== 8'h00 || dir_out !== NONE) begin
            n_fail++;
            $display("FAIL arst_clear: flags=%b w_data=%h err=%0d dir=%0d want 0 00 0 0",
                     {wr_uart, rd_uart, link_up, tx_busy, rcvdir, rcvcol, rcvclick},
                     w_data, err_cnt, dir_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_log();
        repeat (30) @(negedge clk);
        n_cmp++;
        if (data_q.size() != 0 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_stale: data writes=%0d busy=%b want 0 0", data_q.size(), tx_busy);
        end
    endtask

    task automatic test_rx_random();
        logic [7:0] b;
        logic [2:0] s;
        int op, pay;
        bit got;
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 3);
            if (op == 0)      pay = $urandom_range(0, 1) ? 0 : $urandom_range(1, 63);
            else if (op == 1) pay = $urandom_range(0, 1) ? $urandom_range(0, 4) : $urandom_range(8, 63);
            else              pay = $urandom_range(0, 63);
            b = {2'(op), 6'(pay)};
            rx_byte(b, got);
            s = rx_model(b);
            n_cmp++;
            if (!got || {rcvdir, rcvcol, rcvclick} !== s || dir_out !== exp_dir ||
                col_out !== exp_col || click_out !== exp_click || err_cnt !== 8'(exp_err)) begin
                n_fail++;
                $display("FAIL rx_rand[%0d] byte %h: got=%b str=%b dir=%0d col=%h clk=%h err=%0d want 1 %b %0d %h %h %0d",
                         k, b, got, {rcvdir, rcvcol, rcvclick}, dir_out, col_out, click_out,
                         err_cnt, s, exp_dir, exp_col, exp_click, exp_err);
            end
        end
    endtask

    task automatic test_tx_random();
        logic [7:0] exp[$];
        logic [5:0] p;
        int t;
        drain();
        clear_log();
        for (int k = 0; k < 20; k++) begin
            t = $urandom_range(0, 2);
            p = 6'($urandom_range(0, 63));
            if (t == 0) begin
                col_in = p; send_col = 1'b1; exp.push_back({2'b10, p});
            end else if (t == 1) begin
                p = 6'($urandom_range(0, 4));
                dir_in = direction'(p[2:0]); send_dir = 1'b1; exp.push_back({2'b01, p});
            end else begin
                click_in = p; send_click = 1'b1; exp.push_back({2'b11, p});
            end
            @(negedge clk);
            send_col = 1'b0; send_dir = 1'b0; send_click = 1'b0;
            repeat ($urandom_range(2, 5)) @(negedge clk);
        end
        wait_data(exp.size(), 100);
        n_cmp++;
        if (data_q.size() != exp.size()) begin
            n_fail++;
            $display("FAIL tx_rand_count: got %0d want %0d", data_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < data_q.size(); i++) begin
            n_cmp++;
            if (data_q[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL tx_rand[%0d]: got %h want %h", i, data_q[i], exp[i]);
            end
        end
        for (int i = 1; i < tx_t.size(); i++) begin
            n_cmp++;
            if (tx_t[i] - tx_t[i-1] < 2) begin
                n_fail++;
                $display("FAIL tx_rand_spacing[%0d]: gap %0d want >=2", i, tx_t[i] - tx_t[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rx_dir();
        test_err_sat();
        test_tx_priority();
        test_tx_full(5);
        test_tx_full(6);
        test_keepalive_link();
        test_async_reset();
        test_rx_random();
        test_tx_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_link.md
Name: snake_link

Overview:
- Parametrised byte-frame link engine between the snake game core and the UART byte interface (rd_uart/r_data/rx_empty, wr_uart/w_data/tx_full).
- Generalises the single direction exchange to a full opcode set: direction, collision and click, plus keepalive, error counting and a link-loss timeout.
- Outgoing events are edge-detected and queued in a TX FIFO. Incoming bytes are decoded into registered per-opcode outputs with one-cycle strobes.

Parameters:
- FIFO_DEPTH, 4: TX queue depth in bytes; power of two, at least 2.
- KEEPALIVE_CYCLES, 250000: idle TX cycles before a keepalive byte is sent.
- TIMEOUT_CYCLES, 1000000: cycles with no RX byte read before link_up drops.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- send_dir  in  1  level; its rising edge requests a direction frame
- dir_in  in  direction (snake_pkg)  local direction to send
- send_col  in  1  level; its rising edge requests a collision frame
- col_in  in  6  collision payload
- send_click  in  1  level; its rising edge requests a click frame
- click_in  in  6  click payload
- rx_empty  in  1  UART RX FIFO empty
- r_data  in  8  UART RX FIFO head byte
- rd_uart  out  1  UART RX pop strobe
- tx_full  in  1  UART TX FIFO full
- wr_uart  out  1  UART TX push strobe
- w_data  out  8  UART TX byte
- dir_out  out  direction  last received direction
- rcvdir  out  1  one-cycle strobe: dir_out updated
- col_out  out  6  last received collision payload
- rcvcol  out  1  one-cycle strobe: col_out updated
- click_out  out  6  last received click payload
- rcvclick  out  1  one-cycle strobe: click_out updated
- err_cnt  out  8  saturating count of malformed RX bytes
- link_up  out  1  peer alive
- tx_busy  out  1  queue non-empty or any request pending

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n is low, all outputs are 0 and dir_out=NONE. The queue is empty, all pending flags, counters and edge-detect registers are cleared, and any in-flight operation is abandoned. rst_n applies the same reset to every register.
- Frame format: byte[7:6] is the opcode, byte[5:0] is the payload.
  - 00 control: payload 0 is keepalive; any other payload is an error.
  - 01 direction: payload holds the direction value in its low $bits(direction) bits; the upper bits are 0.
  - 10 collision.
  - 11 click.
- TX request capture:
  - A rising edge on send_x (compared with its registered previous value) sets pending_x and latches the payload from dir_in, col_in or click_in.
  - A new edge while pending_x is set overwrites the payload; only the latest value is sent.
- TX enqueue:
  - At most one pending request moves into the queue per cycle, and only if the queue is not full.
  - Priority: collision > direction > click.
  - When the queue is full, requests stay pending and nothing is dropped.
- TX issue:
  - If the queue is non-empty, tx_full=0 and wr_uart was 0 in the previous cycle, then wr_uart=1 for one cycle with w_data=head, and the head is popped.
  - This gives at most one write every 2 cycles.
  - wr_uart and w_data are registered.
- Keepalive:
  - The idle counter increments on each cycle with wr_uart=0 and clears on each wr_uart=1.
  - When it reaches KEEPALIVE_CYCLES-1 with the queue empty and nothing pending, 8'h00 is written under the same tx_full and spacing rules.
  - If tx_full blocks the write, the counter holds at that value.
- RX:
  - If rx_empty=0 and rd_uart was 0 in the previous cycle, r_data is sampled and decoded, and on the next edge rd_uart=1 is registered together with the decoded outputs. The strobe and the data update appear in the same cycle.
  - Strobes last one cycle. Outputs without a strobe hold their value.
  - Malformed bytes (opcode 00 with nonzero payload, or a direction byte with nonzero upper payload bits) produce no strobe and increment err_cnt, which saturates at 255.
- Link monitor:
  - The timeout counter clears on every RX read.
  - link_up goes to 1 in the cycle rd_uart first asserts.
  - link_up goes to 0 when the counter reaches TIMEOUT_CYCLES-1 without a read; the counter then holds.
  - Any later read sets link_up again.
- Simultaneity: TX and RX paths run independently in the same cycle. An edge arriving in the same cycle as its own enqueue is captured as a new pending request.
- tx_busy = (queue non-empty) OR (any pending flag set).

Test Plan:
- Reset, then rx_empty=0 with r_data=8'h40|dir_val(LEFT) -> the next cycle has rd_uart=1, rcvdir=1, dir_out=LEFT and link_up=1. rd_uart is not asserted on the cycle after that.
- send_col, send_dir and send_click rise together (col_in=6'h05, click_in=6'h2A, dir_in=UP), tx_full=0 -> w_data sequence 8'h85, 8'h40|dir_val(UP), 8'hEA. Each write is a single-cycle wr_uart with at least 1 idle cycle between writes.
- tx_full=1, then 5 send_click edges with payloads 1..5 and FIFO_DEPTH=4 -> after release, 8'hC1..8'hC4 then 8'hC5 are written. No write occurs while tx_full=1 and tx_busy=1 throughout.
- Feed bytes 8'h01, then 8'h3F, then 300 times 8'h00 interleaved with 8'h01 -> err_cnt goes 1, 2, then saturates at 255. There are no strobes and 8'h00 produces no error.
- KEEPALIVE_CYCLES=10, TIMEOUT_CYCLES=20, idle with rx_empty=1 -> 8'h00 is written every 11 cycles, and link_up falls 20 cycles after the last read.
- rst_n low asynchronously mid-transmit, with the queue holding 3 bytes -> outputs clear immediately without waiting for clk. After release, no stale bytes are written.
